// File: rtl/screen_pkg.sv
// ---------------------------------------------------------------------------
// screen_pkg
// Shared types and constants for the screen sequencer.
//   screen_t  : which image the pixel pipeline should show (MENU/PLAY/OVER)
//   seq_state_t : sequencer FSM states
//   BRIGHT_MAX  : full brightness level (unity gain in the dimmer)
// ---------------------------------------------------------------------------
package screen_pkg;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } screen_t;

    typedef enum logic [2:0] {
        ST_MENU     = 3'd0,
        ST_PLAY     = 3'd1,
        ST_OVER     = 3'd2,
        ST_FADE_OUT = 3'd3,
        ST_FADE_IN  = 3'd4
    } seq_state_t;

    localparam logic [4:0] BRIGHT_MAX = 5'd16;

    // Resting state that shows a given screen once the fade-in completes.
    function automatic seq_state_t screen_to_state(input screen_t scr);
        seq_state_t st;
        case (scr)
            MENU:    st = ST_MENU;
            PLAY:    st = ST_PLAY;
            default: st = ST_OVER;
        endcase
        return st;
    endfunction

endpackage : screen_pkg

// File: rtl/rgb_dimmer.sv
// ---------------------------------------------------------------------------
// rgb_dimmer
// Scales a 4-bit-per-channel pixel by brightness/16 and forces black outside
// the visible region. One register stage of latency.
// Ports:
//   vga_clk, reset          : pixel clock, synchronous active-high reset
//   red_in/green_in/blue_in : 4-bit source colour
//   brightness              : 0..16, 16 = unity
//   blank                   : 1 while in the visible region
//   red_out/green_out/blue_out : registered dimmed colour
// ---------------------------------------------------------------------------
module rgb_dimmer (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    input  logic [4:0] brightness,
    input  logic       blank,
    output logic [3:0] red_out,
    output logic [3:0] green_out,
    output logic [3:0] blue_out
);

    // 4b x 5b fits in 9 bits; dividing by 16 and keeping 4 bits never
    // overflows because brightness tops out at 16.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] b);
        logic [8:0] prod;
        prod = 9'(c) * 9'(b);
        return 4'(prod >> 4);
    endfunction

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            red_out   <= 4'd0;
            green_out <= 4'd0;
            blue_out  <= 4'd0;
        end else if (blank) begin
            red_out   <= scale(red_in,   brightness);
            green_out <= scale(green_in, brightness);
            blue_out  <= scale(blue_in,  brightness);
        end else begin
            red_out   <= 4'd0;
            green_out <= 4'd0;
            blue_out  <= 4'd0;
        end
    end

endmodule : rgb_dimmer

// File: rtl/screen_sequencer.sv
// ---------------------------------------------------------------------------
// screen_sequencer
// Menu / play / game-over screen sequencing with fade-to-black transitions.
// All screen, target and brightness changes happen on frame_start so that
// the visible image never changes mid-frame.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_MENU     | menu shown at full brightness, waiting for a start press
// ST_PLAY     | game running (game_run = 1), waiting for death
// ST_OVER     | game-over shown; start accepted after OVER_HOLD_FRAMES
// ST_FADE_OUT | dimming by FADE_STEP per frame; at 0 switch screen_sel
// ST_FADE_IN  | brightening by FADE_STEP per frame; at 16 enter screen_sel
//
// Ports:
//   vga_clk, reset     : pixel clock, synchronous active-high reset
//   frame_start        : one-cycle pulse at start of vertical blank
//   start_btn          : debounced button level
//   death              : one-cycle pulse from game logic
//   blank              : 1 in the visible region
//   red/green/blue_in  : source colour for the selected screen
//   screen_sel         : image select (0 MENU, 1 PLAY, 2 OVER)
//   brightness         : current fade level 0..16
//   game_run, busy     : PLAY state / fade in progress
//   red/green/blue_out : dimmed, blank-gated colour, 1 cycle latency
// ---------------------------------------------------------------------------
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int FADE_STEP        = 2,
    parameter int OVER_HOLD_FRAMES = 60
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       start_btn,
    input  logic       death,
    input  logic       blank,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [1:0] screen_sel,
    output logic [4:0] brightness,
    output logic       game_run,
    output logic       busy,
    output logic [3:0] red_out,
    output logic [3:0] green_out,
    output logic [3:0] blue_out
);

    localparam logic [4:0] STEP      = 5'(FADE_STEP);
    localparam logic [7:0] HOLD_MIN  = 8'(OVER_HOLD_FRAMES);

    seq_state_t state, state_nx;
    screen_t    target, target_nx;
    screen_t    sel, sel_nx;
    logic [4:0] bri, bri_nx;
    logic [7:0] hold_cnt, hold_nx;
    logic       start_prev;
    logic       start_pend, start_pend_nx;
    logic       death_pend, death_pend_nx;

    logic       start_edge;
    logic       start_now;
    logic       death_now;
    logic [4:0] bri_dn;
    logic [5:0] bri_sum;
    logic [4:0] bri_up;

    // Events arriving on the frame_start cycle itself are folded in here so
    // they are acted on at that frame rather than lost when the flags clear.
    assign start_edge = start_btn & ~start_prev;
    assign start_now  = start_pend | start_edge;
    assign death_now  = death_pend | death;

    assign bri_dn  = (bri > STEP) ? (bri - STEP) : 5'd0;
    assign bri_sum = {1'b0, bri} + {1'b0, STEP};
    assign bri_up  = (bri_sum >= {1'b0, BRIGHT_MAX}) ? BRIGHT_MAX : bri_sum[4:0];

    always_comb begin
        state_nx      = state;
        target_nx     = target;
        sel_nx        = sel;
        bri_nx        = bri;
        hold_nx       = hold_cnt;
        start_pend_nx = start_pend | start_edge;
        death_pend_nx = death_pend | death;

        // Held at zero outside OVER, so it always starts from 0 on entry.
        if (state != ST_OVER) begin
            hold_nx = 8'd0;
        end else if (frame_start && (hold_cnt != 8'hFF)) begin
            hold_nx = hold_cnt + 8'd1;
        end

        if (frame_start) begin
            start_pend_nx = 1'b0;
            death_pend_nx = 1'b0;
            case (state)
                ST_MENU: begin
                    if (start_now) begin
                        state_nx  = ST_FADE_OUT;
                        target_nx = PLAY;
                    end
                end
                ST_PLAY: begin
                    // Death takes priority; a pending start is simply dropped.
                    if (death_now) begin
                        state_nx  = ST_FADE_OUT;
                        target_nx = OVER;
                    end
                end
                ST_OVER: begin
                    if (start_now && (hold_cnt >= HOLD_MIN)) begin
                        state_nx  = ST_FADE_OUT;
                        target_nx = MENU;
                    end
                end
                ST_FADE_OUT: begin
                    if (bri == 5'd0) begin
                        state_nx = ST_FADE_IN;
                        sel_nx   = target;
                    end else begin
                        bri_nx = bri_dn;
                    end
                end
                ST_FADE_IN: begin
                    if (bri == BRIGHT_MAX) begin
                        state_nx = screen_to_state(sel);
                    end else begin
                        bri_nx = bri_up;
                    end
                end
                default: begin
                    state_nx = ST_MENU;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state      <= ST_MENU;
            target     <= MENU;
            sel        <= MENU;
            bri        <= BRIGHT_MAX;
            hold_cnt   <= 8'd0;
            start_pend <= 1'b0;
            death_pend <= 1'b0;
            // Preset high so a button held through reset is not a press.
            start_prev <= 1'b1;
        end else begin
            state      <= state_nx;
            target     <= target_nx;
            sel        <= sel_nx;
            bri        <= bri_nx;
            hold_cnt   <= hold_nx;
            start_pend <= start_pend_nx;
            death_pend <= death_pend_nx;
            start_prev <= start_btn;
        end
    end

    assign screen_sel = sel;
    assign brightness = bri;
    assign game_run   = (state == ST_PLAY);
    assign busy       = (state == ST_FADE_OUT) || (state == ST_FADE_IN);

    rgb_dimmer u_dimmer (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .red_in     (red_in),
        .green_in   (green_in),
        .blue_in    (blue_in),
        .brightness (bri),
        .blank      (blank),
        .red_out    (red_out),
        .green_out  (green_out),
        .blue_out   (blue_out)
    );

endmodule : screen_sequencer

// File: tb/tb_screen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_screen_sequencer
// Directed stimulus with a scoreboard: stimulus pushes expected state after
// each frame_start/reset and expected colour after each pixel; a monitor pops
// and compares half a cycle after the edge that consumed the stimulus.
// ---------------------------------------------------------------------------
module tb_screen_sequencer;

    logic       vga_clk;
    logic       reset;
    logic       frame_start;
    logic       start_btn;
    logic       death;
    logic       blank;
    logic [3:0] red_in, green_in, blue_in;
    logic [1:0] screen_sel;
    logic [4:0] brightness;
    logic       game_run;
    logic       busy;
    logic [3:0] red_out, green_out, blue_out;

    screen_sequencer #(.FADE_STEP(2), .OVER_HOLD_FRAMES(60)) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .frame_start(frame_start),
        .start_btn  (start_btn),
        .death      (death),
        .blank      (blank),
        .red_in     (red_in),
        .green_in   (green_in),
        .blue_in    (blue_in),
        .screen_sel (screen_sel),
        .brightness (brightness),
        .game_run   (game_run),
        .busy       (busy),
        .red_out    (red_out),
        .green_out  (green_out),
        .blue_out   (blue_out)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int         tag;
        logic [1:0] sel;
        logic [4:0] bri;
        logic       run;
        logic       bsy;
    } st_exp_t;

    typedef struct {
        int         tag;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } col_exp_t;

    st_exp_t  st_q[$];
    col_exp_t col_q[$];

    int   checks = 0;
    int   errors = 0;
    int   tag_ctr = 0;
    int   gap = 100;
    logic col_vld;
    logic ev_st, ev_col;

    // ---------------- stimulus helpers ----------------
    task automatic push_st(input logic [1:0] s, input logic [4:0] b,
                           input logic r, input logic bs);
        st_exp_t e;
        tag_ctr++;
        e.tag = tag_ctr; e.sel = s; e.bri = b; e.run = r; e.bsy = bs;
        st_q.push_back(e);
    endtask

    task automatic frame(input logic [1:0] s, input logic [4:0] b,
                         input logic r, input logic bs);
        @(negedge vga_clk);
        frame_start = 1'b1;
        push_st(s, b, r, bs);
        @(negedge vga_clk);
        frame_start = 1'b0;
        repeat (gap - 2) @(negedge vga_clk);
    endtask

    task automatic press();
        @(negedge vga_clk);
        start_btn = 1'b1;
        repeat (3) @(negedge vga_clk);
        start_btn = 1'b0;
    endtask

    task automatic pulse_death();
        @(negedge vga_clk);
        death = 1'b1;
        @(negedge vga_clk);
        death = 1'b0;
    endtask

    task automatic col(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                       input logic bl, input logic [3:0] er, input logic [3:0] eg,
                       input logic [3:0] eb);
        col_exp_t e;
        @(negedge vga_clk);
        red_in = r; green_in = g; blue_in = b; blank = bl;
        col_vld = 1'b1;
        tag_ctr++;
        e.tag = tag_ctr; e.r = er; e.g = eg; e.b = eb;
        col_q.push_back(e);
        @(negedge vga_clk);
        col_vld = 1'b0;
    endtask

    // Reset with a bright visible pixel on the inputs: RGB must still be 0.
    task automatic do_reset();
        col_exp_t e;
        @(negedge vga_clk);
        reset = 1'b1;
        red_in = 4'd15; green_in = 4'd15; blue_in = 4'd15; blank = 1'b1;
        col_vld = 1'b1;
        push_st(2'd0, 5'd16, 1'b0, 1'b0);
        tag_ctr++;
        e.tag = tag_ctr; e.r = 4'd0; e.g = 4'd0; e.b = 4'd0;
        col_q.push_back(e);
        @(negedge vga_clk);
        reset = 1'b0;
        col_vld = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        st_exp_t  se;
        col_exp_t ce;
        forever begin
            @(posedge vga_clk);
            ev_st  = frame_start | reset;
            ev_col = col_vld;
            if (ev_st || ev_col) begin
                @(negedge vga_clk);
                if (ev_st) begin
                    checks++;
                    if (st_q.size() == 0) begin
                        errors++;
                        $display("FAIL state_unexpected: frame/reset with empty scoreboard, got sel=%0d bri=%0d",
                                 screen_sel, brightness);
                    end else begin
                        se = st_q.pop_front();
                        if (screen_sel !== se.sel || brightness !== se.bri ||
                            game_run !== se.run || busy !== se.bsy) begin
                            errors++;
                            $display("FAIL state#%0d: got sel=%0d bri=%0d run=%0b busy=%0b, expected sel=%0d bri=%0d run=%0b busy=%0b",
                                     se.tag, screen_sel, brightness, game_run, busy,
                                     se.sel, se.bri, se.run, se.bsy);
                        end
                    end
                end
                if (ev_col) begin
                    checks++;
                    if (col_q.size() == 0) begin
                        errors++;
                        $display("FAIL colour_unexpected: pixel with empty scoreboard, got rgb=%0d,%0d,%0d",
                                 red_out, green_out, blue_out);
                    end else begin
                        ce = col_q.pop_front();
                        if (red_out !== ce.r || green_out !== ce.g || blue_out !== ce.b) begin
                            errors++;
                            $display("FAIL colour#%0d: got rgb=%0d,%0d,%0d expected %0d,%0d,%0d",
                                     ce.tag, red_out, green_out, blue_out, ce.r, ce.g, ce.b);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b0; frame_start = 1'b0; start_btn = 1'b1; death = 1'b0;
        blank = 1'b0; red_in = 4'd0; green_in = 4'd0; blue_in = 4'd0;
        col_vld = 1'b0;

        // Start fade, frames 100 cycles apart; button held through reset.
        gap = 100;
        do_reset();
        frame(2'd0, 5'd16, 1'b0, 1'b0);
        @(negedge vga_clk);
        start_btn = 1'b0;
        col(4'd15, 4'd7, 4'd1, 1'b1, 4'd15, 4'd7, 4'd1);
        col(4'd15, 4'd15, 4'd15, 1'b0, 4'd0, 4'd0, 4'd0);
        press();
        frame(2'd0, 5'd16, 1'b0, 1'b1);
        frame(2'd0, 5'd14, 1'b0, 1'b1);
        col(4'd9, 4'd3, 4'd15, 1'b1, 4'd7, 4'd2, 4'd13);
        for (int i = 2; i <= 8; i++) begin
            frame(2'd0, 5'(16 - 2 * i), 1'b0, 1'b1);
            if (i == 4) col(4'd15, 4'd15, 4'd2, 1'b1, 4'd7, 4'd7, 4'd1);
        end
        col(4'd15, 4'd15, 4'd15, 1'b1, 4'd0, 4'd0, 4'd0);
        frame(2'd1, 5'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) frame(2'd1, 5'(2 * i), 1'b0, 1'b1);
        frame(2'd1, 5'd16, 1'b1, 1'b0);

        // Start alone in PLAY is discarded; start + death together -> OVER.
        gap = 10;
        press();
        frame(2'd1, 5'd16, 1'b1, 1'b0);
        press();
        pulse_death();
        frame(2'd1, 5'd16, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) frame(2'd1, 5'(16 - 2 * i), 1'b0, 1'b1);
        frame(2'd2, 5'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) frame(2'd2, 5'(2 * i), 1'b0, 1'b1);
        frame(2'd2, 5'd16, 1'b0, 1'b0);

        // OVER hold: count of frames spent in OVER so far is tracked here.
        pulse_death();
        frame(2'd2, 5'd16, 1'b0, 1'b0);              // hold 0 -> 1, death ignored
        for (int i = 2; i <= 10; i++) frame(2'd2, 5'd16, 1'b0, 1'b0);
        press();
        frame(2'd2, 5'd16, 1'b0, 1'b0);              // hold 10: ignored
        for (int i = 12; i <= 59; i++) frame(2'd2, 5'd16, 1'b0, 1'b0);
        press();
        frame(2'd2, 5'd16, 1'b0, 1'b0);              // hold 59: ignored
        press();
        frame(2'd2, 5'd16, 1'b0, 1'b1);              // hold 60: accepted
        for (int i = 1; i <= 5; i++) frame(2'd2, 5'(16 - 2 * i), 1'b0, 1'b1);

        // Reset at brightness 6 mid fade-out.
        do_reset();

        // Start edge on the frame_start cycle itself.
        @(negedge vga_clk);
        frame_start = 1'b1;
        start_btn = 1'b1;
        push_st(2'd0, 5'd16, 1'b0, 1'b1);
        @(negedge vga_clk);
        frame_start = 1'b0;
        repeat (3) @(negedge vga_clk);
        start_btn = 1'b0;
        repeat (gap) @(negedge vga_clk);
        for (int i = 1; i <= 8; i++) frame(2'd0, 5'(16 - 2 * i), 1'b0, 1'b1);
        frame(2'd1, 5'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) frame(2'd1, 5'(2 * i), 1'b0, 1'b1);
        frame(2'd1, 5'd16, 1'b1, 1'b0);

        // Death pulse on the frame_start cycle itself.
        @(negedge vga_clk);
        frame_start = 1'b1;
        death = 1'b1;
        push_st(2'd1, 5'd16, 1'b0, 1'b1);
        @(negedge vga_clk);
        frame_start = 1'b0;
        death = 1'b0;
        repeat (gap) @(negedge vga_clk);
        for (int i = 1; i <= 8; i++) frame(2'd1, 5'(16 - 2 * i), 1'b0, 1'b1);
        frame(2'd2, 5'd0, 1'b0, 1'b1);

        repeat (4) @(negedge vga_clk);
        checks++;
        if (st_q.size() != 0 || col_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d state and %0d colour entries left, expected 0",
                     st_q.size(), col_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_screen_sequencer

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 FADE_STEP, default 2: brightness change per frame during fades; legal values 1..16.
REQ-002 OVER_HOLD_FRAMES, default 60: minimum number of frames spent in OVER before start is accepted; legal values 1..255.
REQ-003 vga_clk  input  1  pixel clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse at the start of vertical blank.
REQ-006 start_btn  input  1  debounced level, high while pressed.
REQ-007 death  input  1  one-cycle pulse from game logic.
REQ-008 blank  input  1  high while in the visible region.
REQ-009 red_in, green_in, blue_in  input  4 each  pixel colour from the selected image ROM/palette.
REQ-010 screen_sel  output  2  0 = MENU image, 1 = PLAY, 2 = OVER; 3 is never driven.
REQ-011 brightness  output  5  current fade level, 0..16.
REQ-012 game_run  output  1  high only while in the PLAY state.
REQ-013 busy  output  1  high in FADE_OUT and FADE_IN.
REQ-014 red_out, green_out, blue_out  output  4 each  dimmed, blank-gated colour.

Function
REQ-015 The state machine SHALL have the states MENU, PLAY, OVER, FADE_OUT and FADE_IN, plus a registered 2-bit target screen.
REQ-016 All state, target and brightness updates SHALL occur only on cycles where frame_start = 1.
REQ-017 A start_btn rising edge (registered previous value is 0, current value is 1) SHALL set a start_pend flag.
- A death pulse SHALL set a death_pend flag.
- Both flags SHALL stay set until the next frame_start, at which point they are consumed or discarded.
REQ-018 Transitions on frame_start:
- MENU with start_pend: go to FADE_OUT, target = PLAY.
- PLAY with death_pend: go to FADE_OUT, target = OVER.
- OVER with start_pend and hold_cnt >= OVER_HOLD_FRAMES: go to FADE_OUT, target = MENU.
REQ-019 In FADE_OUT, each frame_start SHALL set brightness = max(brightness - FADE_STEP, 0).
- When brightness is already 0, the block SHALL go to FADE_IN and load screen_sel with the target instead.
REQ-020 In FADE_IN, each frame_start SHALL set brightness = min(brightness + FADE_STEP, 16).
- When brightness is already 16, the block SHALL go to the state named by screen_sel.
REQ-021 screen_sel SHALL change only at the FADE_OUT-to-FADE_IN transition, which is while brightness = 0.
REQ-022 hold_cnt (8-bit, saturating) SHALL clear on entry to OVER and increment on each frame_start while in OVER.
REQ-023 At every frame_start, the block SHALL clear start_pend and death_pend regardless of the current state.
- A start_pend arriving in PLAY, FADE_OUT or FADE_IN SHALL therefore be discarded.
- A death_pend arriving outside PLAY SHALL be discarded.
REQ-024 If an edge or pulse arrives on the same cycle as frame_start, it SHALL be acted on at that frame_start; a pulse is never lost.
REQ-025 If start and death are both pending in PLAY, death SHALL win; start has no effect.
REQ-026 Colour path:
- When blank = 1: red_out = (red_in * brightness) >> 4, computed as an unsigned 9-bit product truncated to 4 bits; likewise for green and blue.
- When blank = 0: the output SHALL be 0.
- The path SHALL be registered with exactly 1 cycle of latency.
REQ-027 game_run SHALL equal 1 exactly when the state is PLAY; busy SHALL be 1 exactly when the state is FADE_OUT or FADE_IN.

Reset
REQ-028 On reset the block SHALL force:
- state = MENU, target = MENU, screen_sel = 0, brightness = 16
- hold_cnt = 0, start_pend = 0, death_pend = 0
- game_run = 0, busy = 0, RGB outputs = 0
- previous start_btn register = 1, so a button held through reset does not register as a press.
REQ-029 Reset mid-fade SHALL abandon the fade immediately and restore full brightness on the MENU screen.

Structure
REQ-030 A shared package screen_pkg SHALL hold:
- the screen_t enum (MENU = 0, PLAY = 1, OVER = 2)
- the sequencer state enum
- BRIGHT_MAX = 16.
REQ-031 The colour path SHALL be one sub-module, rgb_dimmer: 3x4-bit colour, 5-bit brightness, blank in; registered 3x4-bit out.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Start fade (FADE_STEP = 2): reset, start_btn press in MENU, frame_start every 100 cycles.
  -> brightness 16,14,...,0 over 8 frames; screen_sel 0->1 at the 9th frame; ramps back to 16; game_run = 1 one frame after brightness reaches 16.
- Death fade: death pulse in PLAY -> FADE_OUT with target OVER, screen_sel = 2 at brightness 0; hold_cnt counts from 0.
- OVER hold (OVER_HOLD_FRAMES = 60): start press at hold_cnt = 10 -> ignored, stays in OVER; start press at hold_cnt = 60 -> FADE_OUT with target MENU.
- Simultaneous events: start and death in the same frame while in PLAY -> target OVER. Pulse on the same cycle as frame_start -> acted on at that frame_start. start_btn held high through reset -> no transition.
- Colour path: red_in = 15 with brightness 16 -> 15; brightness 8 -> 7; brightness 0 -> 0. blank = 0 -> 0. Each result appears one cycle after the input.
- Reset mid-operation: assert reset when brightness = 6 in FADE_OUT -> next cycle state = MENU, brightness = 16, screen_sel = 0, busy = 0.
